// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding and price-table helper for the vending controller.
package vend_pkg;
    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_e;

    localparam int MAX_ITEMS = 16;
    localparam int MAX_CW    = 32;

    // Table is zero-extended to the widest supported shape so one function serves every instance.
    function automatic logic [MAX_CW-1:0] price_of(
        input logic [MAX_ITEMS*MAX_CW-1:0] prices,
        input int                          cw,
        input int                          id
    );
        logic [MAX_CW-1:0] p;
        logic [8:0]        idx;
        p = '0;
        for (int b = 0; b < MAX_CW; b++) begin
            idx = 9'(id * cw + b);
            if (b < cw) p[b] = prices[idx];
        end
        return p;
    endfunction
endpackage

// File: rtl/vend_change_ctrl_price_lut.sv
// vend_price_lut: combinational price lookup with item-index range check.
module vend_price_lut
    import vend_pkg::*;
#(
    parameter int                      NUM_ITEMS = 4,
    parameter int                      CW        = 8,
    parameter int                      IW        = 2,
    parameter logic [NUM_ITEMS*CW-1:0] PRICES    = '0
) (
    input  logic [IW-1:0] id,
    output logic [CW-1:0] price,
    output logic          in_range
);
    logic [MAX_ITEMS*MAX_CW-1:0] table_ext;
    logic [MAX_CW-1:0]           p_full;

    assign table_ext = (MAX_ITEMS*MAX_CW)'(PRICES);
    assign p_full    = price_of(table_ext, CW, int'(id));
    assign price     = p_full[CW-1:0];
    assign in_range  = 32'(id) < NUM_ITEMS;

    if (CW < MAX_CW) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^p_full[MAX_CW-1:CW];
    end
endmodule

// File: rtl/vend_change_ctrl.sv
// vend_change_ctrl: coin credit accumulator, priced selection, dispense pulse and change handshake.
module vend_change_ctrl
    import vend_pkg::*;
#(
    parameter int                      NUM_ITEMS = 4,
    parameter int                      CW        = 8,
    parameter logic [NUM_ITEMS*CW-1:0] PRICES    = {8'd5, 8'd4, 8'd3, 8'd2},
    localparam int                     IW        = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          coin_valid,
    input  logic [CW-1:0] coin_value,
    input  logic          sel_valid,
    input  logic [IW-1:0] sel_id,
    input  logic          cancel,
    input  logic          change_ready,
    output logic [CW-1:0] credit,
    output logic          coin_reject,
    output logic          sel_err,
    output logic          dispense_valid,
    output logic [IW-1:0] dispense_id,
    output logic          change_valid,
    output logic [CW-1:0] change_amt,
    output logic          busy
);
    state_e        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d, amt_q, amt_d;
    logic [IW-1:0] id_q, id_d;
    logic          coin_reject_q, coin_reject_d, sel_err_q, sel_err_d;
    logic [CW-1:0] price;
    logic          in_range, sel_ok;
    logic [CW:0]   sum;

    vend_price_lut #(.NUM_ITEMS(NUM_ITEMS), .CW(CW), .IW(IW), .PRICES(PRICES)) u_lut (
        .id       (sel_id),
        .price    (price),
        .in_range (in_range)
    );

    assign sum    = {1'b0, credit_q} + {1'b0, coin_value};
    assign sel_ok = sel_valid && in_range && (credit_q >= price);

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        amt_d         = amt_q;
        id_d          = id_q;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;
        case (state_q)
            IDLE, CREDIT: begin
                if (cancel && state_q == CREDIT) begin
                    state_d       = CHANGE;
                    amt_d         = credit_q;
                    coin_reject_d = coin_valid;
                end else if (sel_ok) begin
                    state_d       = VEND;
                    id_d          = sel_id;
                    credit_d      = credit_q - price;
                    coin_reject_d = coin_valid;
                end else begin
                    // A refused selection does not consume the cycle, so a coin is still taken.
                    sel_err_d = sel_valid;
                    if (coin_valid && sum[CW]) begin
                        coin_reject_d = 1'b1;
                    end else if (coin_valid) begin
                        credit_d = sum[CW-1:0];
                        state_d  = (sum[CW-1:0] == '0) ? IDLE : CREDIT;
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_valid;
                sel_err_d     = sel_valid;
                amt_d         = credit_q;
                state_d       = (credit_q != '0) ? CHANGE : IDLE;
            end
            default: begin
                coin_reject_d = coin_valid;
                sel_err_d     = sel_valid;
                state_d       = change_ready ? IDLE : CHANGE;
                credit_d      = change_ready ? '0 : credit_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            amt_q         <= '0;
            id_q          <= '0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            amt_q         <= amt_d;
            id_q          <= id_d;
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
        end
    end

    assign credit         = credit_q;
    assign coin_reject    = coin_reject_q;
    assign sel_err        = sel_err_q;
    assign dispense_valid = (state_q == VEND);
    assign dispense_id    = id_q;
    assign change_valid   = (state_q == CHANGE);
    assign change_amt     = amt_q;
    assign busy           = dispense_valid || change_valid;
endmodule

// File: tb/tb_vend_change_ctrl.sv
// tb_vend_change_ctrl: vector table, random run against a reference model, and parameter corner cases.
module tb_vend_change_ctrl;
    logic       clk = 1'b0;
    logic       reset, coin_valid, sel_valid, cancel, change_ready;
    logic [7:0] coin_value;
    logic [3:0] coin_value4;
    logic [1:0] sel_id;

    always #5 clk = ~clk;

    logic [7:0] credit, change_amt;
    logic [1:0] dispense_id;
    logic       coin_reject, sel_err, dispense_valid, change_valid, busy;

    logic [7:0] credit3, change_amt3;
    logic [1:0] dispense_id3;
    logic       coin_reject3, sel_err3, dispense_valid3, change_valid3, busy3;

    logic [3:0] credit4, change_amt4;
    logic [1:0] dispense_id4;
    logic       coin_reject4, sel_err4, dispense_valid4, change_valid4, busy4;

    vend_change_ctrl dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .change_ready(change_ready),
        .credit(credit), .coin_reject(coin_reject), .sel_err(sel_err),
        .dispense_valid(dispense_valid), .dispense_id(dispense_id),
        .change_valid(change_valid), .change_amt(change_amt), .busy(busy)
    );

    vend_change_ctrl #(.NUM_ITEMS(3), .CW(8), .PRICES(24'h04_03_02)) dut3 (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .change_ready(change_ready),
        .credit(credit3), .coin_reject(coin_reject3), .sel_err(sel_err3),
        .dispense_valid(dispense_valid3), .dispense_id(dispense_id3),
        .change_valid(change_valid3), .change_amt(change_amt3), .busy(busy3)
    );

    vend_change_ctrl #(.NUM_ITEMS(4), .CW(4), .PRICES(16'h5432)) dut4 (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value4),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .change_ready(change_ready),
        .credit(credit4), .coin_reject(coin_reject4), .sel_err(sel_err4),
        .dispense_valid(dispense_valid4), .dispense_id(dispense_id4),
        .change_valid(change_valid4), .change_amt(change_amt4), .busy(busy4)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dc(input string name, input logic [31:0] act, input int exp);
        if (exp >= 0) check(name, act, exp);
    endtask

    // Reference model: the transaction is tracked as a credit balance plus "dispensing" and "owed change" flags.
    int prices[4] = '{2, 3, 4, 5};
    int m_credit, m_vend, m_id, m_owe, m_amt, m_rej, m_err;

    task automatic model_step();
        int took;
        if (reset) begin
            m_credit = 0; m_vend = 0; m_id = 0; m_owe = 0; m_amt = 0; m_rej = 0; m_err = 0;
            return;
        end
        m_rej = 0;
        m_err = 0;
        if (m_vend != 0) begin
            m_rej = int'(coin_valid);
            m_err = int'(sel_valid);
            m_vend = 0;
            if (m_credit > 0) begin
                m_owe = 1;
                m_amt = m_credit;
            end
        end else if (m_owe != 0) begin
            m_rej = int'(coin_valid);
            m_err = int'(sel_valid);
            if (change_ready) begin
                m_owe = 0;
                m_credit = 0;
            end
        end else begin
            took = 0;
            if (cancel && m_credit > 0) begin
                m_owe = 1;
                m_amt = m_credit;
                took = 1;
            end else if (sel_valid) begin
                if (m_credit >= prices[sel_id]) begin
                    m_credit -= prices[sel_id];
                    m_vend = 1;
                    m_id = int'(sel_id);
                    took = 1;
                end else begin
                    m_err = 1;
                end
            end
            if (coin_valid) begin
                if (took != 0 || m_credit + int'(coin_value) > 255) m_rej = 1;
                else m_credit += int'(coin_value);
            end
        end
    endtask

    task automatic model_check();
        check("mdl_credit", credit, m_credit);
        check("mdl_coin_reject", coin_reject, m_rej);
        check("mdl_sel_err", sel_err, m_err);
        check("mdl_dispense_valid", dispense_valid, m_vend);
        check("mdl_change_valid", change_valid, m_owe);
        check("mdl_busy", busy, int'(m_vend != 0 || m_owe != 0));
        if (m_vend != 0) check("mdl_dispense_id", dispense_id, m_id);
        if (m_owe != 0) check("mdl_change_amt", change_amt, m_amt);
    endtask

    task automatic drive(input int r, cv, cval, sv, sid, cn, rdy);
        reset        = (r != 0);
        coin_valid   = (cv != 0);
        coin_value   = 8'(cval);
        coin_value4  = 4'(cval);
        sel_valid    = (sv != 0);
        sel_id       = 2'(sid);
        cancel       = (cn != 0);
        change_ready = (rdy != 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    typedef struct {
        int r, cv, cval, sv, sid, cn, rdy;
        int credit, crej, serr, dv, did, chv, chamt, busy;
    } vec_t;

    vec_t tv[$];

    initial begin
        // inputs: reset coin val sel id cancel ready | expected: credit rej err disp id chv amt busy (-1 = don't care)
        tv.push_back('{1,0,0,0,0,0,0,  0,0,0,0,0,0,0,0});
        tv.push_back('{0,1,2,0,0,0,0,  2,0,0,0,-1,0,-1,0});
        tv.push_back('{0,1,2,0,0,0,0,  4,0,0,0,-1,0,-1,0});
        tv.push_back('{0,0,0,1,0,0,0,  2,0,0,1,0,0,-1,1});
        tv.push_back('{0,0,0,0,0,0,0,  2,0,0,0,-1,1,2,1});
        tv.push_back('{0,0,0,0,0,0,0,  2,0,0,0,-1,1,2,1});
        tv.push_back('{0,0,0,0,0,0,0,  2,0,0,0,-1,1,2,1});
        tv.push_back('{0,0,0,0,0,0,1,  0,0,0,0,-1,0,-1,0});
        tv.push_back('{0,1,3,0,0,0,0,  3,0,0,0,-1,0,-1,0});
        tv.push_back('{0,0,0,1,1,0,0,  0,0,0,1,1,0,-1,1});
        tv.push_back('{0,0,0,0,0,0,0,  0,0,0,0,-1,0,-1,0});
        tv.push_back('{0,1,3,0,0,0,0,  3,0,0,0,-1,0,-1,0});
        tv.push_back('{0,0,0,1,3,0,0,  3,0,1,0,-1,0,-1,0});
        tv.push_back('{0,0,0,0,0,0,0,  3,0,0,0,-1,0,-1,0});
        tv.push_back('{0,1,1,0,0,0,0,  4,0,0,0,-1,0,-1,0});
        tv.push_back('{0,1,1,1,0,1,0,  4,1,0,0,-1,1,4,1});
        tv.push_back('{0,1,1,1,2,1,0,  4,1,1,0,-1,1,4,1});
        tv.push_back('{0,0,0,0,0,0,1,  0,0,0,0,-1,0,-1,0});
        tv.push_back('{0,1,2,0,0,0,0,  2,0,0,0,-1,0,-1,0});
        tv.push_back('{0,0,0,0,0,1,0,  2,0,0,0,-1,1,2,1});
        tv.push_back('{1,1,7,1,0,1,1,  0,0,0,0,0,0,0,0});
        tv.push_back('{0,1,1,0,0,0,0,  1,0,0,0,-1,0,-1,0});
        tv.push_back('{0,0,0,0,0,1,0,  1,0,0,0,-1,1,1,1});
        tv.push_back('{0,0,0,0,0,0,1,  0,0,0,0,-1,0,-1,0});
        tv.push_back('{0,0,0,0,0,1,0,  0,0,0,0,-1,0,-1,0});
        tv.push_back('{0,1,5,0,0,0,0,  5,0,0,0,-1,0,-1,0});
        tv.push_back('{0,0,0,0,0,0,1,  5,0,0,0,-1,0,-1,0});
        tv.push_back('{0,0,0,0,0,1,0,  5,0,0,0,-1,1,5,1});
        tv.push_back('{0,0,0,0,0,0,1,  0,0,0,0,-1,0,-1,0});
        tv.push_back('{0,1,4,0,0,0,0,  4,0,0,0,-1,0,-1,0});
        tv.push_back('{0,0,0,1,0,0,0,  2,0,0,1,0,0,-1,1});
        tv.push_back('{0,1,1,1,1,1,0,  2,1,1,0,-1,1,2,1});
        tv.push_back('{0,0,0,0,0,0,1,  0,0,0,0,-1,0,-1,0});

        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].r, tv[i].cv, tv[i].cval, tv[i].sv, tv[i].sid, tv[i].cn, tv[i].rdy);
            step();
            check_dc("tv_credit", credit, tv[i].credit);
            check_dc("tv_coin_reject", coin_reject, tv[i].crej);
            check_dc("tv_sel_err", sel_err, tv[i].serr);
            check_dc("tv_dispense_valid", dispense_valid, tv[i].dv);
            check_dc("tv_dispense_id", dispense_id, tv[i].did);
            check_dc("tv_change_valid", change_valid, tv[i].chv);
            check_dc("tv_change_amt", change_amt, tv[i].chamt);
            check_dc("tv_busy", busy, tv[i].busy);
        end

        for (int i = 0; i < 600; i++) begin
            drive(int'($urandom_range(0, 99) == 0),
                  int'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 4) == 0),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, 2) == 0));
            step();
        end

        // Narrow-credit overflow and a short item table, driven through the shared inputs.
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        check("cw4_reset_credit", credit4, 0);
        check("n3_reset_credit", credit3, 0);
        drive(0, 1, 14, 0, 0, 0, 0);
        step();
        check("cw4_credit14", credit4, 14);
        drive(0, 1, 5, 0, 0, 0, 0);
        step();
        check("cw4_ovf_reject", coin_reject4, 1);
        check("cw4_ovf_credit", credit4, 14);
        drive(0, 1, 1, 0, 0, 0, 0);
        step();
        check("cw4_fill_reject", coin_reject4, 0);
        check("cw4_credit15", credit4, 15);
        check("n3_credit20", credit3, 20);
        drive(0, 0, 0, 1, 3, 0, 0);
        step();
        check("n3_range_err", sel_err3, 1);
        check("n3_range_nodisp", dispense_valid3, 0);
        check("n3_range_credit", credit3, 20);
        check("cw4_sel3_disp", dispense_valid4, 1);
        check("cw4_sel3_id", dispense_id4, 3);
        check("cw4_sel3_credit", credit4, 10);
        drive(0, 0, 0, 1, 2, 0, 0);
        step();
        check("n3_sel2_disp", dispense_valid3, 1);
        check("n3_sel2_id", dispense_id3, 2);
        check("n3_sel2_credit", credit3, 16);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        check("n3_change_valid", change_valid3, 1);
        check("n3_change_amt", change_amt3, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vend_change_ctrl.md
# vend_change_ctrl

Parametrised vending controller that succeeds the fixed two-product change calculator. It accumulates coin credit and validates a product selection against a per-item price table. On a successful selection it issues a one-cycle dispense pulse, then presents the change on a valid/ready handshake toward the coin-return mechanism. It sits between the coin acceptor / keypad front end and the dispense and change actuators.

## Interface
- NUM_ITEMS, 4, number of selectable products (1..16)
- CW, 8, credit/price/change width in bits
- PRICES, {8'd5,8'd4,8'd3,8'd2}, packed NUM_ITEMS*CW price table; item i at bits [i*CW +: CW] (item0=2, item1=3 keep legacy A/B pricing)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- coin_valid  in  1  coin inserted this cycle
- coin_value  in  CW  value of inserted coin
- sel_valid  in  1  selection request this cycle
- sel_id  in  $clog2(NUM_ITEMS) (min 1)  requested item index
- cancel  in  1  abort transaction, refund credit
- change_ready  in  1  coin-return mechanism accepts change
- credit  out  CW  current accumulated credit
- coin_reject  out  1  one-cycle pulse: coin not accepted
- sel_err  out  1  one-cycle pulse: selection refused
- dispense_valid  out  1  one-cycle dispense pulse
- dispense_id  out  $clog2(NUM_ITEMS)  item dispensed, valid with dispense_valid
- change_valid  out  1  change_amt valid, held until accepted
- change_amt  out  CW  change to return
- busy  out  1  high in VEND or CHANGE

## Operation
- States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE.
- Priority within a cycle in IDLE/CREDIT: cancel > sel_valid > coin_valid. A coin_valid in the same cycle as an accepted cancel or selection is dropped and coin_reject pulses.
- Coin: if credit+coin_value (computed CW+1 bits) > 2^CW-1, the coin is rejected (coin_reject pulses) and credit is unchanged. Otherwise credit += coin_value and the FSM moves to CREDIT. A coin_value of 0 is accepted as a no-op.
- Selection: sel_id >= NUM_ITEMS, or credit < PRICES[sel_id], gives a sel_err pulse with no state change. Otherwise the selection is latched and the FSM goes to VEND. Remainder = credit - price, which never underflows.
- VEND (exactly 1 cycle): dispense_valid=1 and dispense_id=latched id. Next state is CHANGE if remainder>0, else IDLE with credit=0.
- Cancel in CREDIT: go to CHANGE with remainder=credit; no dispense. Cancel in IDLE is a no-op.
- CHANGE: change_valid=1 and change_amt=remainder, both stable until change_ready. On change_valid&&change_ready: IDLE, credit=0, change_valid drops the next cycle.
- In VEND/CHANGE: coins give coin_reject; sel_valid gives sel_err; cancel is ignored.
- credit reads the live register. It shows the remainder during CHANGE and 0 after the handshake.

## Timing
- Reset: state IDLE; credit, change_amt, and dispense_id are 0; all pulses and valids are 0. Reset mid-CHANGE discards the pending change.
- All outputs are registered. Effects appear the cycle after the input edge.
- Coin at edge N: credit updates at N+1.
- Selection at edge N: dispense_valid at N+1; change_valid from N+2 at the earliest.
- Cancel at edge N: change_valid at N+1.
- change_ready while change_valid=0 is ignored. A handshake completes in the same cycle change_ready is sampled high.
- Minimum transaction turnaround: the next coin is accepted the cycle after the return to IDLE.

## Structure
- Package vend_pkg holds the state enum (IDLE, CREDIT, VEND, CHANGE) and the function price_of(PRICES, id).
- Sub-module vend_price_lut does the combinational price lookup plus the id-range check. It outputs the price and an in_range flag.
- Datapath and FSM live in one always block with separate next-state logic.

## Test plan
- Default params: coins 2,2 then sel 0 → credit 2,4; dispense_id 0; change_valid with change_amt 2 held 3 cycles until change_ready; then credit 0 and IDLE.
- Exact price: coin 3, sel 1 → dispense, no change_valid, IDLE next cycle.
- Insufficient/invalid: credit 3, sel 3 (price 5) → sel_err, credit stays 3. With NUM_ITEMS=3, sel_id 3 → sel_err.
- Overflow: CW=4, credit 14, coin 5 → coin_reject, credit 14. A following coin 1 → credit 15.
- Simultaneous: credit 4, cancel+sel+coin in one cycle → cancel wins, change_amt 4, coin_reject, no dispense.
- Reset during CHANGE (change_amt 2) → all outputs 0 the next cycle; a following coin 1 → credit 1.
